// File: rtl/study_guide_pkg.sv
// rtl/study_guide_pkg.sv - shared mode, note, one-hot and state codes plus song contents
package study_guide_pkg;

  localparam logic [2:0] mode_free  = 3'd0;
  localparam logic [2:0] mode_study = 3'd1;
  localparam logic [2:0] mode_play  = 3'd2;

  localparam logic [2:0] n_rest = 3'd0;
  localparam logic [2:0] n_do   = 3'd1;
  localparam logic [2:0] n_re   = 3'd2;
  localparam logic [2:0] n_mi   = 3'd3;
  localparam logic [2:0] n_fa   = 3'd4;
  localparam logic [2:0] n_so   = 3'd5;
  localparam logic [2:0] n_la   = 3'd6;
  localparam logic [2:0] n_q1   = 3'd7;

  localparam logic [6:0] h_space = 7'b0000000;
  localparam logic [6:0] h_do    = 7'b0000001;
  localparam logic [6:0] h_re    = 7'b0000010;
  localparam logic [6:0] h_mi    = 7'b0000100;
  localparam logic [6:0] h_fa    = 7'b0001000;
  localparam logic [6:0] h_so    = 7'b0010000;
  localparam logic [6:0] h_la    = 7'b0100000;
  localparam logic [6:0] h_q1    = 7'b1000000;

  typedef enum logic [2:0] {
    st_idle,
    st_fetch,
    st_load,
    st_wait_rel,
    st_wait_press,
    st_advance,
    st_done
  } state_t;

  function automatic logic [6:0] note_onehot(input logic [2:0] code);
    if (code == n_rest) return h_space;
    return 7'(7'b1 << (code - 3'd1));
  endfunction

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

  // Song 0 opens do, re, rest, mi; the remaining slots cycle through the scale.
  function automatic logic [2:0] song_note(input logic [1:0] song, input logic [4:0] addr);
    int v;
    v = (int'(addr) + 2 * int'(song) + 1) % 8;
    if (song == 2'd0) begin
      case (addr)
        5'd0:    return n_do;
        5'd1:    return n_re;
        5'd2:    return n_rest;
        5'd3:    return n_mi;
        default: return v[2:0];
      endcase
    end
    return v[2:0];
  endfunction

endpackage

// File: rtl/study_guide_if.sv
// rtl/study_guide_if.sv - player/LED-side bundle of the study sequencer
interface study_guide_if;
  logic [2:0] mode;
  logic       start;
  logic [1:0] song_sel;
  logic [6:0] key_note;
  logic [6:0] study_note_control;
  logic [2:0] tone_note;
  logic       busy;
  logic       done;
  logic [4:0] hit_cnt;
  logic [4:0] miss_cnt;

  modport master (
    output mode, start, song_sel, key_note,
    input  study_note_control, tone_note, busy, done, hit_cnt, miss_cnt
  );

  modport slave (
    input  mode, start, song_sel, key_note,
    output study_note_control, tone_note, busy, done, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/study_song_rom.sv
// rtl/study_song_rom.sv - four-song note ROM with one cycle of read latency
module study_song_rom
  import study_guide_pkg::*;
(
  input  logic       clk,
  input  logic [1:0] song,
  input  logic [4:0] addr,
  output logic [2:0] code
);

  always_ff @(posedge clk) begin
    code <= song_note(song, addr);
  end

endmodule

// File: rtl/study_guide.sv
// rtl/study_guide.sv - study-mode note sequencer; STUDY_HINT_BLINK_EN blinks the hint while waiting
module study_guide
  import study_guide_pkg::*;
#(
  parameter int SONG_LEN    = 16,
  parameter int TIMEOUT_CYC = 100000000,
  parameter int BLINK_CYC   = 25000000
) (
  input  logic         clk,
  input  logic         rst_n,
  study_guide_if.slave bus
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYC + 1);

  if (SONG_LEN < 1 || SONG_LEN > 32) begin : g_bad_len
    $error("SONG_LEN out of range");
  end
  if (BLINK_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_cyc
    $error("cycle counts must be positive");
  end

  state_t               state;
  logic [1:0]           song_q;
  logic [4:0]           index;
  logic [2:0]           rom_code;
  logic [6:0]           expect_oh;
  logic [6:0]           led;
  logic [2:0]           tone;
  logic                 busy_q;
  logic                 done_q;
  logic [4:0]           hit_q;
  logic [4:0]           miss_q;
  logic [TIMER_W-1:0]   timer;

`ifdef STUDY_HINT_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_CYC + 1);
  logic [BLINK_W-1:0] blink_cnt;
`endif

  study_song_rom u_rom (
    .clk  (clk),
    .song (song_q),
    .addr (index),
    .code (rom_code)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= st_idle;
      song_q    <= 2'd0;
      index     <= 5'd0;
      expect_oh <= h_space;
      led       <= h_space;
      tone      <= n_rest;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hit_q     <= 5'd0;
      miss_q    <= 5'd0;
      timer     <= '0;
`ifdef STUDY_HINT_BLINK_EN
      blink_cnt <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      // Leaving study mode mid-song drops straight to idle; scores are kept.
      if (state != st_idle && bus.mode != mode_study) begin
        state     <= st_idle;
        expect_oh <= h_space;
        led       <= h_space;
        tone      <= n_rest;
        busy_q    <= 1'b0;
      end else begin
        case (state)
          st_idle: begin
            if (bus.start && bus.mode == mode_study) begin
              state  <= st_fetch;
              song_q <= bus.song_sel;
              index  <= 5'd0;
              hit_q  <= 5'd0;
              miss_q <= 5'd0;
              busy_q <= 1'b1;
            end
          end
          st_fetch: state <= st_load;
          st_load: begin
            if (rom_code == n_rest) begin
              state <= st_advance;
            end else begin
              expect_oh <= note_onehot(rom_code);
              led       <= note_onehot(rom_code);
              tone      <= rom_code;
              state     <= st_wait_rel;
            end
          end
          st_wait_rel: begin
            if (bus.key_note == 7'd0) begin
              state <= st_wait_press;
              timer <= '0;
`ifdef STUDY_HINT_BLINK_EN
              blink_cnt <= '0;
`endif
            end
          end
          st_wait_press: begin
            // A press on the timeout cycle takes priority over the timeout.
            if (bus.key_note != 7'd0) begin
              if (bus.key_note == expect_oh) begin
                hit_q     <= sat_inc(hit_q);
                expect_oh <= h_space;
                led       <= h_space;
                tone      <= n_rest;
                state     <= st_advance;
              end else begin
                miss_q <= sat_inc(miss_q);
                led    <= expect_oh;
                state  <= st_wait_rel;
              end
            end else if (timer == TIMER_W'(TIMEOUT_CYC - 1)) begin
              miss_q    <= sat_inc(miss_q);
              expect_oh <= h_space;
              led       <= h_space;
              tone      <= n_rest;
              state     <= st_advance;
            end else begin
              timer <= timer + 1'b1;
`ifdef STUDY_HINT_BLINK_EN
              if (blink_cnt == BLINK_W'(BLINK_CYC - 1)) begin
                blink_cnt <= '0;
                led       <= (led == h_space) ? expect_oh : h_space;
              end else begin
                blink_cnt <= blink_cnt + 1'b1;
              end
`endif
            end
          end
          st_advance: begin
            if (index == 5'(SONG_LEN - 1)) begin
              state  <= st_done;
              done_q <= 1'b1;
            end else begin
              index <= index + 5'd1;
              state <= st_fetch;
            end
          end
          st_done: begin
            state     <= st_idle;
            expect_oh <= h_space;
            led       <= h_space;
            tone      <= n_rest;
            busy_q    <= 1'b0;
          end
          default: state <= st_idle;
        endcase
      end
    end
  end

  assign bus.study_note_control = led;
  assign bus.tone_note          = tone;
  assign bus.busy               = busy_q;
  assign bus.done               = done_q;
  assign bus.hit_cnt            = hit_q;
  assign bus.miss_cnt           = miss_q;

endmodule

// File: tb/tb_study_guide.sv
// tb/tb_study_guide.sv - directed bench for study_guide (SONG_LEN=4, TIMEOUT_CYC=20)
module tb_study_guide;
  import study_guide_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   done_seen = 0;

  study_guide_if bus ();

  study_guide #(
    .SONG_LEN    (4),
    .TIMEOUT_CYC (20),
    .BLINK_CYC   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_seen <= done_seen + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Assumes the DUT has just shown the note (WAIT_REL): one idle cycle, then the press.
  task automatic press(input logic [6:0] keys);
    bus.key_note = 7'd0;
    tick();
    bus.key_note = keys;
    tick();
    bus.key_note = 7'd0;
  endtask

  // Waits up to 30 cycles for the LED to show exp; any other lit pattern meanwhile is an error.
  task automatic wait_led(input string tag, input logic [6:0] exp);
    int stray;
    stray = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.study_note_control == exp) break;
      if (bus.study_note_control != h_space) stray++;
      tick();
    end
    check(tag, {25'd0, bus.study_note_control}, {25'd0, exp});
    check({tag, "_stray"}, stray, 0);
  endtask

  initial begin
    int d0;
    bus.mode     = mode_study;
    bus.start    = 1'b0;
    bus.song_sel = 2'd0;
    bus.key_note = 7'd0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_led", bus.study_note_control, h_space);
    check("rst_busy", bus.busy, 0);
    check("rst_hit", bus.hit_cnt, 0);

    bus.mode = mode_free;
    pulse_start();
    tick();
    check("start_wrong_mode", bus.busy, 0);
    bus.mode = mode_study;

    // Full song with correct presses; the rest slot shows nothing.
    d0 = done_seen;
    pulse_start();
    check("busy_fetch", bus.busy, 1);
    tick();
    check("led_start_p1", bus.study_note_control, h_space);
    tick();
    check("led_start_p2", bus.study_note_control, h_do);
    check("tone_do", bus.tone_note, n_do);
    press(h_do);
    check("hit_after_do", bus.hit_cnt, 1);
    wait_led("show_re", h_re);
    check("tone_re", bus.tone_note, n_re);
    press(h_re);
    wait_led("show_mi", h_mi);
    press(h_mi);
    for (int i = 0; i < 5; i++) tick();
    check("song_hits", bus.hit_cnt, 3);
    check("song_miss", bus.miss_cnt, 0);
    check("song_done_once", done_seen - d0, 1);
    check("song_idle_busy", bus.busy, 0);
    check("song_idle_tone", bus.tone_note, 0);

    // Wrong key, then the right one, then abort by leaving study mode.
    d0 = done_seen;
    pulse_start();
    wait_led("b_show_do", h_do);
    check("b_counts_cleared", bus.hit_cnt, 0);
    press(h_re);
    check("b_miss", bus.miss_cnt, 1);
    check("b_still_do", bus.study_note_control, h_do);
    press(h_do);
    check("b_hit", bus.hit_cnt, 1);
    wait_led("b_show_re", h_re);
    tick();
    bus.mode = mode_free;
    tick();
    check("abort_led", bus.study_note_control, h_space);
    check("abort_busy", bus.busy, 0);
    check("abort_tone", bus.tone_note, 0);
    check("abort_hit_hold", bus.hit_cnt, 1);
    tick();
    check("abort_no_done", done_seen - d0, 0);
    bus.mode = mode_study;

    // Key held through LOAD must be released before it counts.
    bus.key_note = h_do;
    pulse_start();
    wait_led("c_show_do", h_do);
    for (int i = 0; i < 5; i++) tick();
    check("c_held_no_hit", bus.hit_cnt, 0);
    check("c_held_no_miss", bus.miss_cnt, 0);
    press(h_do);
    check("c_hit_after_release", bus.hit_cnt, 1);
    bus.mode = mode_free;
    tick();
    bus.mode = mode_study;

    // Every note times out.
    d0 = done_seen;
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      if (done_seen != d0) break;
      tick();
    end
    check("d_done", done_seen - d0, 1);
    check("d_miss", bus.miss_cnt, 3);
    check("d_hit", bus.hit_cnt, 0);
    tick();
    tick();
    check("d_idle", bus.busy, 0);

    // Reset in the middle of WAIT_PRESS.
    pulse_start();
    wait_led("e_show_do", h_do);
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("e_led", bus.study_note_control, h_space);
    check("e_tone", bus.tone_note, 0);
    check("e_busy", bus.busy, 0);
    check("e_done", bus.done, 0);
    check("e_hit", bus.hit_cnt, 0);
    check("e_miss", bus.miss_cnt, 0);
    tick();
    check("e_stays_idle", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
